operand_fetch_sequencer: RTL

OPERAND_FETCH_SEQUENCER -- requirements
Module: operand_fetch_sequencer

---
 rtl/operand_fetch_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer: takes one instruction over a valid/ready handshake,
// reads operands A and B through a shared, arbitrated register-file read port,
// and presents an operand bundle over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       instruction handshake; in_instr, in_imm payload
//   rf_rd_en/rf_rd_addr     register-file read request
//   rf_rd_gnt/rf_rd_data    grant this cycle; data the cycle after a grant
//   out_valid/out_ready     bundle handshake
//   out_op_a, out_op_b      operands
//   out_dst                 destination register index
//   out_illegal             reserved bits set in a reg-reg instruction
module operand_fetch_sequencer #(
    parameter int WORD_SIZE    = 16,
    parameter int IMM_SIGN_EXT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_instr,
    input  logic                 in_imm,
    output logic                 rf_rd_en,
    output logic [2:0]           rf_rd_addr,
    input  logic                 rf_rd_gnt,
    input  logic [WORD_SIZE-1:0] rf_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_op_a,
    output logic [WORD_SIZE-1:0] out_op_b,
    output logic [2:0]           out_dst,
    output logic                 out_illegal
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ_A = 3'd1;
    localparam logic [2:0] GOT_A = 3'd2;
    localparam logic [2:0] REQ_B = 3'd3;
    localparam logic [2:0] GOT_B = 3'd4;
    localparam logic [2:0] OUT   = 3'd5;

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [10:0]          instr;
    logic                 imm;
    logic [WORD_SIZE-1:0] op_a;
    logic [WORD_SIZE-1:0] op_b;
    logic [2:0]           dst;
    logic                 illegal;

    logic [2:0]           a_addr;
    logic [2:0]           b_addr;
    logic                 ext_bit;
    logic [WORD_SIZE-1:0] imm_ext;

    assign a_addr  = imm ? instr[10:8] : instr[6:4];
    assign b_addr  = instr[2:0];
    assign ext_bit = (IMM_SIGN_EXT != 0) ? instr[7] : 1'b0;
    assign imm_ext = {{(WORD_SIZE-8){ext_bit}}, instr[7:0]};

    // Request and next-state logic. GOT_A doubles as the first B request
    // cycle for reg-reg instructions so a continuous grant costs no bubble.
    always_comb begin
        state_next = state;
        rf_rd_en   = 1'b0;
        rf_rd_addr = a_addr;
        case (state)
            IDLE: begin
                if (in_valid) state_next = REQ_A;
            end
            REQ_A: begin
                rf_rd_en = 1'b1;
                if (rf_rd_gnt) state_next = GOT_A;
            end
            GOT_A: begin
                if (imm) begin
                    state_next = OUT;
                end else begin
                    rf_rd_en   = 1'b1;
                    rf_rd_addr = b_addr;
                    state_next = rf_rd_gnt ? GOT_B : REQ_B;
                end
            end
            REQ_B: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = b_addr;
                if (rf_rd_gnt) state_next = GOT_B;
            end
            GOT_B: begin
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            instr   <= '0;
            imm     <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            dst     <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        instr   <= in_instr[10:0];
                        imm     <= in_imm;
                        dst     <= in_imm ? in_instr[10:8] : in_instr[6:4];
                        illegal <= ~in_imm & (in_instr[7] | in_instr[3]);
                    end
                end
                GOT_A: begin
                    op_a <= rf_rd_data;
                    if (imm) op_b <= imm_ext;
                end
                GOT_B: begin
                    op_b <= rf_rd_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == OUT);
    assign out_op_a    = op_a;
    assign out_op_b    = op_b;
    assign out_dst     = dst;
    assign out_illegal = illegal;

endmodule
